// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if: ROM, redirect and decode-side signals of the prefetch queue
interface fetch_prefetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                         fetch_en;
    logic [ADDR_W-1:0]            imem_addr;
    logic [DATA_W-1:0]            imem_instr;
    logic                         redirect;
    logic [ADDR_W-1:0]            redirect_target;
    logic                         ID_ready;
    logic                         ID_valid;
    logic [DATA_W-1:0]            ID_instruction;
    logic [ADDR_W-1:0]            ID_PC;
    logic [ADDR_W-1:0]            ID_NextPC;
    logic [$clog2(DEPTH+1)-1:0]   count;
    modport master (
        input  fetch_en, imem_instr, redirect, redirect_target, ID_ready,
        output imem_addr, ID_valid, ID_instruction, ID_PC, ID_NextPC, count
    );
    modport slave (
        output fetch_en, imem_instr, redirect, redirect_target, ID_ready,
        input  imem_addr, ID_valid, ID_instruction, ID_PC, ID_NextPC, count
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential fetch into a FWFT queue of {PC, PC+4, instruction} with branch flush
module fetch_prefetch_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input logic Clk,
    input logic Reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [ADDR_W-1:0] fetch_pc;
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic              valid, pop, push;
    assign valid = cnt != '0;
    assign pop   = valid & bus.ID_ready & ~bus.redirect;
    assign push  = bus.fetch_en & ~bus.redirect & ((cnt < CW'(DEPTH)) | pop);
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            fetch_pc <= ADDR_W'(RESET_PC);
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_target & ~ADDR_W'(3);
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (pop)
                head <= head + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    // Entry storage needs no reset: outputs are masked whenever the queue is empty
    always_ff @(posedge Clk)
        if (push) begin
            pc_q[tail]    <= fetch_pc;
            instr_q[tail] <= bus.imem_instr;
        end
    assign bus.imem_addr      = fetch_pc;
    assign bus.count          = cnt;
    assign bus.ID_valid       = valid;
    assign bus.ID_instruction = valid ? instr_q[head] : '0;
    assign bus.ID_PC          = valid ? pc_q[head] : '0;
    assign bus.ID_NextPC      = valid ? pc_q[head] + ADDR_W'(4) : '0;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed stimulus with a pop-side scoreboard for fetch_prefetch_queue
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4, ADDR_W = 8, DATA_W = 32;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int n_tests = 0, n_fail = 0;
    logic [2*ADDR_W+DATA_W-1:0] exp_q[$];
    fetch_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    fetch_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );
    always #5 Clk = ~Clk;
    assign bus.imem_instr = 32'hE000_0000 + 32'(bus.imem_addr >> 2);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic expect_pop(input logic [7:0] pc, input logic [7:0] npc);
        exp_q.push_back({pc, npc, 32'hE000_0000 + 32'(pc >> 2)});
    endtask
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask
    task automatic rst_cycle();
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("no_bypass_valid", 32'(bus.ID_valid), 0);
        chk("reset_imem_addr", 32'(bus.imem_addr), 0);
        tick();
    endtask
    initial forever begin
        @(negedge Clk);
        if (Reset && bus.ID_valid && bus.ID_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got PC %h expected no pop", bus.ID_PC);
            end else begin
                logic [2*ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", 32'(bus.ID_PC), 32'(e[2*ADDR_W+DATA_W-1 -: ADDR_W]));
                chk("pop_nextpc", 32'(bus.ID_NextPC), 32'(e[ADDR_W+DATA_W-1 -: ADDR_W]));
                chk("pop_instr", bus.ID_instruction, e[DATA_W-1:0]);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.fetch_en = 1'b1;
        bus.ID_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = '0;
        #1;
        chk("rst_valid", 32'(bus.ID_valid), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_pc", 32'(bus.ID_PC), 0);
        @(posedge Clk);
        #1;
        rst_cycle();
        // streaming: one instruction per cycle, occupancy stays at one
        chk("lat_valid", 32'(bus.ID_valid), 1);
        chk("lat_pc", 32'(bus.ID_PC), 0);
        bus.ID_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_pop(8'(4 * i), 8'(4 * i + 4));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_count", 32'(bus.count), 1);
            chk("stream_pc", 32'(bus.ID_PC), 32'(4 * (i + 1)));
        end
        bus.ID_ready = 1'b0;
        rst_cycle();
        chk("fill_count", 32'(bus.count), 1);
        for (int i = 1; i < 6; i++) begin
            tick();
            chk("fill_count", 32'(bus.count), (i + 1 > 4) ? 4 : i + 1);
        end
        chk("full_imem_addr", 32'(bus.imem_addr), 16);
        for (int i = 0; i < 5; i++) expect_pop(8'(4 * i), 8'(4 * i + 4));
        bus.ID_ready = 1'b1;
        repeat (5) tick();
        chk("drain_full_count", 32'(bus.count), 4);
        bus.ID_ready = 1'b0;
        rst_cycle();
        repeat (3) tick();
        expect_pop(8'h00, 8'h04);
        expect_pop(8'h04, 8'h08);
        bus.ID_ready = 1'b1;
        repeat (2) tick();
        bus.ID_ready = 1'b0;
        chk("pre_redir_count", 32'(bus.count), 4);
        chk("pre_redir_head", 32'(bus.ID_PC), 8);
        bus.redirect = 1'b1;
        bus.redirect_target = 8'h41;
        tick();
        bus.redirect = 1'b0;
        chk("redir_count", 32'(bus.count), 0);
        chk("redir_valid", 32'(bus.ID_valid), 0);
        chk("redir_imem_addr", 32'(bus.imem_addr), 32'h40);
        chk("redir_pc_zero", 32'(bus.ID_PC), 0);
        chk("redir_instr_zero", bus.ID_instruction, 0);
        tick();
        chk("target_valid", 32'(bus.ID_valid), 1);
        chk("target_pc", 32'(bus.ID_PC), 32'h40);
        chk("target_nextpc", 32'(bus.ID_NextPC), 32'h44);
        chk("target_instr", bus.ID_instruction, 32'hE000_0010);
        repeat (3) tick();
        chk("refill_count", 32'(bus.count), 4);
        bus.ID_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 8'h80;
        tick();
        bus.redirect = 1'b0;
        bus.ID_ready = 1'b0;
        chk("redir_pop_count", 32'(bus.count), 0);
        chk("redir_pop_addr", 32'(bus.imem_addr), 32'h80);
        // PC wrap at 2^ADDR_W
        bus.redirect = 1'b1;
        bus.redirect_target = 8'hF8;
        tick();
        bus.redirect = 1'b0;
        expect_pop(8'hF8, 8'hFC);
        expect_pop(8'hFC, 8'h00);
        expect_pop(8'h00, 8'h04);
        bus.ID_ready = 1'b1;
        repeat (2) tick();
        chk("wrap_pc", 32'(bus.ID_PC), 32'hFC);
        chk("wrap_nextpc", 32'(bus.ID_NextPC), 0);
        tick();
        chk("wrap_next_pc", 32'(bus.ID_PC), 0);
        tick();
        bus.ID_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 8'h20;
        tick();
        bus.redirect = 1'b0;
        repeat (3) tick();
        chk("pre_async_count", 32'(bus.count), 3);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_valid", 32'(bus.ID_valid), 0);
        chk("async_count", 32'(bus.count), 0);
        chk("async_pc", 32'(bus.ID_PC), 0);
        chk("async_nextpc", 32'(bus.ID_NextPC), 0);
        chk("async_instr", bus.ID_instruction, 0);
        chk("async_imem_addr", 32'(bus.imem_addr), 0);
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        chk("restart_valid", 32'(bus.ID_valid), 1);
        chk("restart_pc", 32'(bus.ID_PC), 0);
        chk("restart_count", 32'(bus.count), 1);
        repeat (2) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
